// File: rtl/gpio_pkg.sv
// Shared AHB encodings, register count and bridge state type for the GPIO bus front ends.
package gpio_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam int NUM_GPIO_REGS = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ_WAIT,
      ST_READ_DONE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_t;

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a free OKAY.
   function automatic logic htransActive(input logic [1:0] htrans);
      logic active;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
         default:                   active = 1'b0;
      endcase
      return active;
   endfunction

endpackage

// File: rtl/gpio_ahb_addr_check.sv
// Combinational legality check for a word-register bus access: word size, word alignment and index range.
module gpio_ahb_addr_check
   import gpio_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = NUM_GPIO_REGS
) (
   input  logic [WIDTH-1:0] haddr_i,
   input  logic [2:0]       hsize_i,
   output logic             legal_o
);

   localparam logic [WIDTH-3:0] LIMIT = (WIDTH-2)'(NUM_REGS);

   always_comb begin
      legal_o = (hsize_i == HSIZE_WORD) &&
                (haddr_i[1:0] == 2'b00) &&
                (haddr_i[WIDTH-1:2] < LIMIT);
   end

endmodule

// File: rtl/gpio_ahb_bridge.sv
// AHB-Lite slave front end for the GPIO register core: AHB address/data phases become single-cycle core strobes.
// Define GPIO_AHB_ERR_RESP_EN to answer illegal accesses with a two-cycle ERROR response instead of a silent OKAY.
module gpio_ahb_bridge
   import gpio_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_REGS  = NUM_GPIO_REGS,
   parameter int READ_WAIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hsel,
   input  logic [WIDTH-1:0] haddr,
   input  logic [1:0]       htrans,
   input  logic             hwrite,
   input  logic [2:0]       hsize,
   input  logic [WIDTH-1:0] hwdata,
   input  logic             hready,
   output logic             hreadyout,
   output logic             hresp,
   output logic [WIDTH-1:0] hrdata,
   output logic             sel,
   output logic             w_en,
   output logic             r_en,
   output logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] rdata
);

   localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);

   bridge_state_t    state_q, state_d;
   logic [WIDTH-1:0] addrIdx_q, addrIdx_d;
   logic [WIDTH-1:0] readData_q, readData_d;
   logic [2:0]       waitCnt_q, waitCnt_d;
   logic             accept;
   logic             legal;
   logic             canAccept;

   gpio_ahb_addr_check #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS)
   ) u_addrCheck (
      .haddr_i (haddr),
      .hsize_i (hsize),
      .legal_o (legal)
   );

   assign accept = hsel & hready & htransActive(htrans);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addrIdx_q  <= '0;
         readData_q <= '0;
         waitCnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         addrIdx_q  <= addrIdx_d;
         readData_q <= readData_d;
         waitCnt_q  <= waitCnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addrIdx_d  = addrIdx_q;
      readData_d = readData_q;
      waitCnt_d  = waitCnt_q;
      hreadyout  = 1'b1;
      hresp      = 1'b0;
      sel        = 1'b0;
      w_en       = 1'b0;
      r_en       = 1'b0;
      canAccept  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            canAccept = 1'b1;
         end
         ST_WRITE: begin
            sel       = 1'b1;
            w_en      = 1'b1;
            canAccept = 1'b1;
         end
         ST_READ_WAIT: begin
            sel       = 1'b1;
            r_en      = 1'b1;
            hreadyout = 1'b0;
            if (waitCnt_q == 3'd0) begin
               readData_d = rdata;
               state_d    = ST_READ_DONE;
            end else begin
               waitCnt_d = waitCnt_q - 3'd1;
            end
         end
         ST_READ_DONE: begin
            canAccept = 1'b1;
         end
`ifdef GPIO_AHB_ERR_RESP_EN
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            hresp     = 1'b1;
            canAccept = 1'b1;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Any cycle that ends a data phase with hreadyout high may also carry the next address phase.
      if (canAccept) begin
         state_d = ST_IDLE;
         if (accept) begin
            addrIdx_d = {2'b00, haddr[WIDTH-1:2]};
            if (legal && hwrite) begin
               state_d = ST_WRITE;
            end else if (legal) begin
               state_d   = ST_READ_WAIT;
               waitCnt_d = WAIT_LOAD;
            end else begin
`ifdef GPIO_AHB_ERR_RESP_EN
               state_d = ST_ERR1;
`else
               state_d = ST_IDLE;
               if (!hwrite) begin
                  readData_d = '0;
               end
`endif
            end
         end
      end
   end

   assign addr   = sel ? addrIdx_q : '0;
   assign wdata  = w_en ? hwdata : '0;
   assign hrdata = readData_q;

endmodule
